relu_maxpool_stage: RTL and testbench

- Streaming stage directly downstream of the convolution branch.
- Consumes signed fixed-point convolution results in row-major order, channel by channel.
- Applies ReLU, then 2x2 max-pooling with stride 2.
- Emits pooled values with a linear write address for the next layer's data memory.

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/pool_line_buffer.sv | 27 ++
 rtl/relu_maxpool_stage.sv | 162 ++++++++++++++++
 tb/tb_relu_maxpool_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Types, widths and arithmetic helpers shared by the CNN datapath stages
// (convolution branch and the ReLU/max-pool stage).
package cnn_pkg;

    localparam int CNN_DATA_WIDTH     = 27;
    localparam int CNN_FRACTION_WIDTH = 8;
    localparam int CNN_ADDR_WIDTH     = 10;

    typedef logic signed [CNN_DATA_WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StFlush
    } pool_state_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic fixed_t relu(input fixed_t x);
        return x[CNN_DATA_WIDTH-1] ? '0 : x;
    endfunction

    function automatic fixed_t fmax(input fixed_t a, input fixed_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Holds the horizontal pair maxima of the even row of each pooling window
// until the matching odd row arrives. Contents are not reset.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH     = 5,
    parameter int IDX_WIDTH = cnt_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  fixed_t               wr_data,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output fixed_t               rd_data
);

    fixed_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/relu_maxpool_stage.sv
// Streaming ReLU followed by 2x2/stride-2 max-pooling over row-major,
// channel-by-channel conv results, with a single-slot output register.
module relu_maxpool_stage
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH         = CNN_DATA_WIDTH,
    parameter int FRACTION_WIDTH     = CNN_FRACTION_WIDTH,
    parameter int ADDR_WIDTH         = CNN_ADDR_WIDTH,
    parameter int CONV_RESULT_WIDTH  = 10,
    parameter int CONV_RESULT_HEIGHT = 10,
    parameter int CHANNEL_NUM        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  done
);

    localparam int PW       = CONV_RESULT_WIDTH / 2;
    localparam int PH       = CONV_RESULT_HEIGHT / 2;
    localparam int COL_W    = cnt_width(CONV_RESULT_WIDTH);
    localparam int ROW_W    = cnt_width(CONV_RESULT_HEIGHT);
    localparam int CH_W     = cnt_width(CHANNEL_NUM);
    localparam int LB_IDX_W = cnt_width(PW);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(CONV_RESULT_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CONV_RESULT_HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM - 1);

    // The datapath works on the shared fixed-point type; the fraction is carried unchanged.
    if (DATA_WIDTH != CNN_DATA_WIDTH) begin : g_width_check
        $error("DATA_WIDTH must equal the cnn_pkg fixed_t width");
    end
    if (FRACTION_WIDTH >= DATA_WIDTH) begin : g_frac_check
        $error("FRACTION_WIDTH must leave at least one integer bit");
    end

    pool_state_e          state;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [CH_W-1:0]      ch;

    fixed_t               r;
    fixed_t               hmax;
    fixed_t               pair;
    fixed_t               lb_rd;
    logic [LB_IDX_W-1:0]  lb_idx;
    logic                 xfer;
    logic                 last_in;
    logic                 lb_we;
    logic                 win_load;
    logic [ADDR_WIDTH-1:0] addr_calc;

    assign in_ready = (state == StActive) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign last_in  = (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);

    assign r    = relu(fixed_t'(in_data));
    assign pair = fmax(hmax, r);

    // An odd col/row is always inside the pooled area, so a trailing odd-sized
    // column or row can never complete a window; it is simply consumed.
    assign lb_we    = xfer && col[0] && !row[0];
    assign win_load = xfer && col[0] && row[0];
    assign lb_idx   = LB_IDX_W'(col >> 1);

    assign addr_calc = ADDR_WIDTH'(ch) * ADDR_WIDTH'(PW * PH)
                     + ADDR_WIDTH'(row >> 1) * ADDR_WIDTH'(PW)
                     + ADDR_WIDTH'(col >> 1);

    pool_line_buffer #(
        .DEPTH     (PW),
        .IDX_WIDTH (LB_IDX_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_idx  (lb_idx),
        .wr_data (pair),
        .rd_idx  (lb_idx),
        .rd_data (lb_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
            col   <= '0;
            row   <= '0;
            ch    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (run) begin
                        state <= StActive;
                        col   <= '0;
                        row   <= '0;
                        ch    <= '0;
                    end
                end
                StActive: begin
                    if (xfer) begin
                        if (last_in) begin
                            state <= StFlush;
                            col   <= '0;
                            row   <= '0;
                            ch    <= '0;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row <= '0;
                                ch  <= ch + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (!out_valid || out_ready) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hmax <= '0;
        end else if (xfer && !col[0]) begin
            hmax <= r;
        end
    end

    // A reload in the same cycle as a drain keeps out_valid high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (win_load) begin
            out_valid <= 1'b1;
            out_data  <= fmax(lb_rd, pair);
            out_addr  <= addr_calc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Scoreboard bench: a 10x10x2 instance and a 5x5x1 instance, expected pooled
// values queued as window-completing samples are accepted.
module tb_relu_maxpool_stage;

    localparam int DW = 27;
    localparam int AW = 10;

    typedef struct {
        int addr;
        int data;
        int acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          run_s       [2];
    logic          in_valid_s  [2];
    logic          in_ready_s  [2];
    logic [DW-1:0] in_data_s   [2];
    logic          out_valid_s [2];
    logic          out_ready_s [2];
    logic [DW-1:0] out_data_s  [2];
    logic [AW-1:0] out_addr_s  [2];
    logic          done_s      [2];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb [$];
    int   frame [2][10][10];
    int   got_data [100];
    int   n_out;
    int   n_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    relu_maxpool_stage u_dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run_s[0]),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .in_data   (in_data_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .out_data  (out_data_s[0]),
        .out_addr  (out_addr_s[0]),
        .done      (done_s[0])
    );

    relu_maxpool_stage #(
        .CONV_RESULT_WIDTH  (5),
        .CONV_RESULT_HEIGHT (5),
        .CHANNEL_NUM        (1)
    ) u_odd (
        .clk       (clk),
        .reset     (reset),
        .run       (run_s[1]),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .in_data   (in_data_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .out_data  (out_data_s[1]),
        .out_addr  (out_addr_s[1]),
        .done      (done_s[1])
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dim_w(input int d);
        return (d == 0) ? 10 : 5;
    endfunction

    function automatic int dim_c(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int win_max(input int c, input int pr, input int pc);
        int m = 0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                if (frame[c][2*pr+dr][2*pc+dc] > m) m = frame[c][2*pr+dr][2*pc+dc];
            end
        end
        return m;
    endfunction

    function automatic int frame_at(input int d, input int idx);
        int w = dim_w(d);
        if (idx >= w * w * dim_c(d)) return 0;
        return frame[idx / (w * w)][(idx / w) % w][idx % w];
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            run_s[d]       = 1'b0;
            in_valid_s[d]  = 1'b0;
            in_data_s[d]   = '0;
            out_ready_s[d] = 1'b0;
        end
    endtask

    // kind 0: ramp + hand-placed ReLU windows, 1: small odd frame, 2: random
    task automatic fill_frame(input int kind);
        for (int c = 0; c < 2; c++) begin
            for (int y = 0; y < 10; y++) begin
                for (int x = 0; x < 10; x++) begin
                    case (kind)
                        0:       frame[c][y][x] = (c == 0) ? y * 10 + x : ((y * 7 + x * 13) % 41) - 20;
                        1:       frame[c][y][x] = (y * 5 + x) * 3 - 20;
                        default: frame[c][y][x] = int'($urandom_range(0, 400)) - 200;
                    endcase
                end
            end
        end
        if (kind == 0) begin
            frame[1][0][0] = -5; frame[1][0][1] = -3; frame[1][1][0] = -8; frame[1][1][1] = -1;
            frame[1][0][2] = -5; frame[1][0][3] = 7;  frame[1][1][2] = 2;  frame[1][1][3] = -1;
            frame[1][8][8] = 67108863;
            frame[1][8][9] = -67108864;
        end
    endtask

    task automatic run_frame(input int d, input bit gaps, input bit stall, input int abort_after);
        int w, total, idx, stall_left, held_d, held_a, tail, c, y, x, a;
        bit seen_head, done_seen;
        exp_t e;
        w = dim_w(d);
        total = w * w * dim_c(d);
        idx = 0; n_out = 0; n_done = 0; tail = 0;
        seen_head = 1'b0; done_seen = 1'b0;
        stall_left = stall ? 5 : 0;
        held_d = 0; held_a = 0;
        for (int i = 0; i < 100; i++) got_data[i] = -1;
        @(posedge clk); #1;
        for (int budget = 0; budget < 3000; budget++) begin
            run_s[d]       = (budget == 0);
            in_valid_s[d]  = (idx < total) && (!gaps || $urandom_range(0, 3) != 0);
            in_data_s[d]   = DW'(frame_at(d, idx));
            out_ready_s[d] = (stall_left == 0);
            @(negedge clk);
            if (out_valid_s[d]) begin
                check_val("out_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0 && !seen_head) begin
                    check_val("latency", cyc, sb[0].acc_cyc + 1);
                    seen_head = 1'b1;
                end
            end
            if (out_valid_s[d] && !out_ready_s[d] && stall_left > 0) begin
                if (stall_left == 5) begin
                    held_d = int'(out_data_s[d]);
                    held_a = int'(out_addr_s[d]);
                end else begin
                    check_val("stall_data", int'(out_data_s[d]), held_d);
                    check_val("stall_addr", int'(out_addr_s[d]), held_a);
                end
                check_val("stall_in_ready", int'(in_ready_s[d]), 0);
                stall_left--;
            end
            if (out_valid_s[d] && out_ready_s[d] && sb.size() > 0) begin
                e = sb.pop_front();
                check_val("out_addr", int'(out_addr_s[d]), e.addr);
                check_val("out_data", int'(out_data_s[d]), e.data);
                if (e.addr < 100) got_data[e.addr] = int'(out_data_s[d]);
                n_out++;
                seen_head = 1'b0;
            end
            if (done_s[d]) begin
                n_done++;
                check_val("done_after_last_input", idx, total);
                done_seen = 1'b1;
            end else if (done_seen) begin
                check_val("idle_in_ready", int'(in_ready_s[d]), 0);
            end
            if (in_valid_s[d] && in_ready_s[d]) begin
                c = idx / (w * w);
                y = (idx / w) % w;
                x = idx % w;
                if (y % 2 == 1 && x % 2 == 1) begin
                    a = c * (w / 2) * (w / 2) + (y / 2) * (w / 2) + x / 2;
                    sb.push_back('{addr: a, data: win_max(c, y / 2, x / 2), acc_cyc: cyc});
                end
                idx++;
            end
            if (abort_after > 0 && idx >= abort_after) break;
            if (done_seen) tail++;
            if (tail > 3) break;
            @(posedge clk); #1;
        end
        if (abort_after == 0) begin
            check_val("frame_done_seen", int'(done_seen), 1);
            check_val("sb_drained", sb.size(), 0);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        // Outputs must stay at reset values whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                run_s[d]       = 1'($urandom_range(0, 1));
                in_valid_s[d]  = 1'($urandom_range(0, 1));
                in_data_s[d]   = DW'($urandom);
                out_ready_s[d] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_val("rst_in_ready", int'(in_ready_s[d]), 0);
                check_val("rst_out_valid", int'(out_valid_s[d]), 0);
                check_val("rst_out_data", int'(out_data_s[d]), 0);
                check_val("rst_out_addr", int'(out_addr_s[d]), 0);
                check_val("rst_done", int'(done_s[d]), 0);
            end
        end
        @(posedge clk); #1;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        fill_frame(0);
        run_frame(0, 1'b0, 1'b0, 0);
        check_val("basic_n_out", n_out, 50);
        check_val("basic_done_count", n_done, 1);
        check_val("basic_first", got_data[0], 11);
        check_val("basic_44", got_data[24], 99);
        check_val("relu_all_neg", got_data[25], 0);
        check_val("relu_mixed", got_data[26], 7);
        check_val("large_positive", got_data[49], 67108863);

        run_frame(0, 1'b0, 1'b1, 0);
        check_val("stall_n_out", n_out, 50);
        check_val("stall_done_count", n_done, 1);
        check_val("stall_first", got_data[0], 11);
        check_val("stall_44", got_data[24], 99);

        fill_frame(1);
        run_frame(1, 1'b1, 1'b0, 0);
        check_val("odd_n_out", n_out, 4);
        check_val("odd_done_count", n_done, 1);
        for (int k = 0; k < 4; k++) check_val("odd_addr_seen", int'(got_data[k] >= 0), 1);
        check_val("odd_no_addr4", got_data[4], -1);

        fill_frame(2);
        run_frame(0, 1'b1, 1'b0, 37);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_val("abort_out_valid", int'(out_valid_s[0]), 0);
        check_val("abort_in_ready", int'(in_ready_s[0]), 0);
        check_val("abort_out_addr", int'(out_addr_s[0]), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        run_frame(0, 1'b1, 1'b0, 0);
        check_val("abort_n_out", n_out, 50);
        check_val("abort_done_count", n_done, 1);
        check_val("abort_first", got_data[0], win_max(0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
